// File: rtl/kp_string_voice_if.sv
// Sample-rate control and audio bus between the noise source, the string voice and the mixer.
// The master drives per-note controls and strobes; the slave returns the voice sample and status.
interface kp_string_voice_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
);
  logic                     sample_en;
  logic                     trig;
  logic signed [DATA_W-1:0] noise;
  logic        [6:0]        velocity;
  logic        [12:0]       decay;
  logic        [ADDR_W-1:0] delay_length;
  logic        [1:0]        filt_mode;
  logic                     reverse;
  logic signed [DATA_W-1:0] sample_out;
  logic                     sample_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output sample_en, trig, noise, velocity, decay, delay_length, filt_mode, reverse,
    input  sample_out, sample_valid, busy, overrun
  );

  modport slave (
    input  sample_en, trig, noise, velocity, decay, delay_length, filt_mode, reverse,
    output sample_out, sample_valid, busy, overrun
  );
endinterface

// File: rtl/kp_string_voice.sv
// Karplus-Strong voice: noise-excited delay line recirculated through a low-pass and decay gain.
// Fixed 3-cycle sample latency; strobes arriving while a sample is in flight are dropped and flag overrun.
module kp_string_voice #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 10,
  parameter int MIN_LEN     = 2,
  parameter int SILENCE_THR = 16
) (
  input  logic             i_audio_clk,
  input  logic             i_reset,
  kp_string_voice_if.slave i_voice
);

  localparam int SUM_W = DATA_W + 2;
  localparam logic [ADDR_W-1:0] MIN_L = ADDR_W'(MIN_LEN);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic signed [DATA_W-1:0] THR_P = DATA_W'(SILENCE_THR);
  localparam logic signed [DATA_W-1:0] THR_N = -THR_P;
  localparam logic [12:0] UNITY = 13'd4096;

  typedef enum logic [1:0] {ST_IDLE, ST_EXCITE, ST_RING} state_t;

  state_t r_state, w_state_nxt, w_mode;
  state_t r_s1_mode, r_s2_mode;

  logic                     r_trig_d;
  logic                     w_rise;
  logic                     w_pipe_busy;
  logic                     w_accept;
  logic                     w_busy;
  logic                     r_overrun;

  logic [ADDR_W-1:0]        r_len, r_ptr, r_cnt;
  logic [ADDR_W-1:0]        w_len_in, w_len, w_ptr, w_cnt;
  logic [ADDR_W-1:0]        w_ptr_inc, w_cnt_inc, w_sil_inc, w_rd_addr;
  logic                     w_exc_last, w_sil_last;

  logic signed [DATA_W+7:0] w_exc_prod;
  logic signed [DATA_W-1:0] w_exc;

  logic                     r_s1_vld;
  logic [ADDR_W-1:0]        r_s1_ptr;
  logic signed [DATA_W-1:0] r_s1_exc;
  logic signed [DATA_W-1:0] r_rd_dat;

  logic signed [DATA_W-1:0] r_h1, r_h2;
  logic signed [SUM_W-1:0]  w_x, w_h1, w_h2, w_sum2, w_sum3;
  logic signed [DATA_W-1:0] w_filt;

  logic                     r_s2_vld, r_s2_live;
  logic [ADDR_W-1:0]        r_s2_ptr;
  logic signed [DATA_W-1:0] r_s2_f;

  logic [12:0]              w_g;
  logic signed [DATA_W+13:0] w_gain_prod;
  logic signed [DATA_W-1:0] w_res;
  logic                     w_silent, w_ring_done, w_wr_en;

  logic signed [DATA_W-1:0] r_out;
  logic                     r_vld;

  logic signed [DATA_W-1:0] r_mem [2**ADDR_W];

  // Upper clamp is implicit: an ADDR_W-bit length can never exceed 2^ADDR_W-1.
  assign w_len_in = (i_voice.delay_length < MIN_L) ? MIN_L : i_voice.delay_length;

  assign w_rise      = i_voice.trig & ~r_trig_d;
  assign w_pipe_busy = r_s1_vld | r_s2_vld | r_vld;
  assign w_accept    = i_voice.sample_en & ~w_pipe_busy;

  // A trigger edge on the same cycle as a strobe makes that sample the first excite sample.
  assign w_mode = w_rise ? ST_EXCITE : r_state;
  assign w_len  = w_rise ? w_len_in : r_len;
  assign w_ptr  = w_rise ? '0 : r_ptr;
  assign w_cnt  = w_rise ? '0 : r_cnt;

  assign w_ptr_inc  = (w_ptr + ONE_A == w_len) ? '0 : w_ptr + ONE_A;
  assign w_cnt_inc  = w_cnt + ONE_A;
  assign w_exc_last = (w_cnt_inc == w_len);
  assign w_sil_inc  = r_cnt + ONE_A;
  assign w_sil_last = (w_sil_inc == r_len);
  assign w_rd_addr  = i_voice.reverse ? (w_len - ONE_A - w_ptr) : w_ptr;

  assign w_exc_prod = $signed(i_voice.noise) * $signed({1'b0, i_voice.velocity});
  assign w_exc      = DATA_W'(w_exc_prod >>> 7);

  assign w_x    = {{2{r_rd_dat[DATA_W-1]}}, r_rd_dat};
  assign w_h1   = {{2{r_h1[DATA_W-1]}}, r_h1};
  assign w_h2   = {{2{r_h2[DATA_W-1]}}, r_h2};
  assign w_sum2 = w_x + w_h1;
  assign w_sum3 = w_x + (w_h1 <<< 1) + w_h2;

  always_comb begin
    w_filt = r_rd_dat;
    case (i_voice.filt_mode)
      2'd1:    w_filt = DATA_W'(w_sum2 >>> 1);
      2'd2:    w_filt = DATA_W'(w_sum3 >>> 2);
      default: w_filt = r_rd_dat;
    endcase
  end

  assign w_g         = (i_voice.decay > UNITY) ? UNITY : i_voice.decay;
  assign w_gain_prod = r_s2_f * $signed({1'b0, w_g});

  always_comb begin
    w_res = '0;
    case (r_s2_mode)
      ST_EXCITE: w_res = r_s2_f;
      ST_RING:   w_res = DATA_W'(w_gain_prod >>> 12);
      default:   w_res = '0;
    endcase
  end

  assign w_silent    = (w_res > THR_N) && (w_res < THR_P);
  assign w_ring_done = r_s2_vld & r_s2_live & (r_s2_mode == ST_RING);
  assign w_wr_en     = r_s2_vld & (r_s2_mode != ST_IDLE) & ~i_reset;

  // State register
  always_ff @(posedge i_audio_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: a trigger edge outranks silence detection from an in-flight sample
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && (w_mode == ST_EXCITE) && w_exc_last)
      w_state_nxt = ST_RING;
    else if (w_rise)
      w_state_nxt = ST_EXCITE;
    else if (w_ring_done && w_silent && w_sil_last)
      w_state_nxt = ST_IDLE;
  end

  // Outputs
  always_comb begin
    w_busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge i_audio_clk) begin
    if (i_reset) begin
      r_trig_d  <= 1'b0;
      r_len     <= MIN_L;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_trig_d <= i_voice.trig;
      if (w_rise) r_len <= w_len_in;
      if (w_accept && (w_mode != ST_IDLE)) r_ptr <= w_ptr_inc;
      else if (w_rise)                     r_ptr <= '0;
      if (w_accept && (w_mode == ST_EXCITE)) r_cnt <= w_exc_last ? '0 : w_cnt_inc;
      else if (w_rise)                       r_cnt <= '0;
      else if (w_ring_done)                  r_cnt <= (w_silent && !w_sil_last) ? w_sil_inc : '0;
      if (i_voice.sample_en && w_pipe_busy) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_audio_clk) begin
    if (i_reset || w_rise) begin
      r_h1 <= '0;
      r_h2 <= '0;
    end else if (r_s1_vld && (r_s1_mode == ST_RING)) begin
      r_h2 <= r_h1;
      r_h1 <= r_rd_dat;
    end
  end

  // Samples overtaken by a trigger edge still emerge, but no longer steer silence detection.
  always_ff @(posedge i_audio_clk) begin
    if (i_reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_mode <= ST_IDLE;
      r_s1_ptr  <= '0;
      r_s1_exc  <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_live <= 1'b0;
      r_s2_mode <= ST_IDLE;
      r_s2_ptr  <= '0;
      r_s2_f    <= '0;
      r_vld     <= 1'b0;
      r_out     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_mode <= w_mode;
        r_s1_ptr  <= w_ptr;
        r_s1_exc  <= w_exc;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_live <= r_s1_vld & ~w_rise;
      if (r_s1_vld) begin
        r_s2_mode <= r_s1_mode;
        r_s2_ptr  <= r_s1_ptr;
        r_s2_f    <= (r_s1_mode == ST_EXCITE) ? r_s1_exc : w_filt;
      end
      r_vld <= r_s2_vld;
      if (r_s2_vld) r_out <= w_res;
    end
  end

  always_ff @(posedge i_audio_clk) begin
    if (w_accept) r_rd_dat <= r_mem[w_rd_addr];
    if (w_wr_en)  r_mem[r_s2_ptr] <= w_res;
  end

  assign i_voice.sample_out   = r_out;
  assign i_voice.sample_valid = r_vld;
  assign i_voice.busy         = w_busy;
  assign i_voice.overrun      = r_overrun;

endmodule

// File: tb/tb_kp_string_voice.sv
// Scoreboarded bench for kp_string_voice: a sequential string model predicts every sample,
// and a monitor matches each sample_valid pulse against the queued prediction and its due cycle.
module tb_kp_string_voice;
  localparam int DW = 24;
  localparam int AW = 10;

  typedef struct {
    longint y;
    bit     busy;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  exp_t   sb[$];
  exp_t   mon_e;

  longint m_mem[1024];
  int     m_state, m_ptr, m_len, m_cnt;
  longint m_h1, m_h2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kp_string_voice_if #(.DATA_W(DW), .ADDR_W(AW)) vif ();

  kp_string_voice #(.DATA_W(DW), .ADDR_W(AW), .MIN_LEN(2), .SILENCE_THR(16)) dut (
    .i_audio_clk (clk),
    .i_reset     (rst),
    .i_voice     (vif)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_len = 2; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic m_trig(input int dl);
    m_len = (dl < 2) ? 2 : dl;
    m_state = 1; m_ptr = 0; m_cnt = 0; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic m_step(output longint y);
    longint x, f, g;
    int ra, wa;
    y = 0;
    if (m_state == 0) return;
    wa = m_ptr;
    ra = vif.reverse ? (m_len - 1 - m_ptr) : m_ptr;
    if (m_state == 1) begin
      y = (longint'(vif.noise) * longint'(vif.velocity)) >>> 7;
      m_mem[wa] = y;
      m_cnt++;
      if (m_cnt == m_len) begin m_state = 2; m_cnt = 0; end
    end else begin
      x = m_mem[ra];
      case (vif.filt_mode)
        2'd1:    f = (x + m_h1) >>> 1;
        2'd2:    f = (x + 2 * m_h1 + m_h2) >>> 2;
        default: f = x;
      endcase
      g = (vif.decay > 4096) ? 64'sd4096 : longint'(vif.decay);
      y = (f * g) >>> 12;
      m_mem[wa] = y;
      m_h2 = m_h1;
      m_h1 = x;
      if (y > -16 && y < 16) m_cnt++;
      else m_cnt = 0;
      if (m_cnt == m_len) begin m_state = 0; m_cnt = 0; end
    end
    m_ptr = (m_ptr + 1 == m_len) ? 0 : m_ptr + 1;
  endtask

  // One accepted strobe: predict, queue the expectation, then idle out the rest of the period.
  task automatic send(input int gap);
    exp_t   e;
    longint y;
    m_step(y);
    e.y = y;
    e.busy = (m_state != 0);
    e.cyc = cyc + 3;
    sb.push_back(e);
    vif.sample_en = 1'b1;
    tick();
    vif.sample_en = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic pluck(input int dl);
    vif.delay_length = AW'(dl);
    vif.trig = 1'b1;
    m_trig(dl);
    tick();
    vif.trig = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (vif.sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", cyc, mon_e.cyc);
        check("sample", vif.sample_out, mon_e.y);
        check("busy", vif.busy, mon_e.busy);
      end
    end
  end

  initial begin
    vif.sample_en = 1'b0; vif.trig = 1'b0; vif.noise = '0; vif.velocity = '0;
    vif.decay = '0; vif.delay_length = '0; vif.filt_mode = '0; vif.reverse = 1'b0;
    m_reset();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out", vif.sample_out, 0);
    check("rst_valid", vif.sample_valid, 0);
    check("rst_busy", vif.busy, 0);
    check("rst_overrun", vif.overrun, 0);
    rst = 1'b0;
    tick();

    // Idle strobes still produce zero-valued samples.
    repeat (3) send(8);
    check("idle_overrun", vif.overrun, 0);

    // Constant excitation, length latched at the trigger, then unity and half gain.
    vif.noise = 24'sd1048576; vif.velocity = 7'd127; vif.decay = 13'd4096;
    pluck(8);
    check("busy_after_trig", vif.busy, 1);
    vif.delay_length = 10'd20;
    repeat (16) send(8);
    vif.decay = 13'd2048;
    repeat (16) send(8);

    // Reverse readout, then two-tap average.
    vif.decay = 13'd4096; vif.reverse = 1'b1;
    pluck(4);
    for (int i = 1; i <= 4; i++) begin vif.noise = DW'(100 * i); send(8); end
    repeat (4) send(8);
    vif.reverse = 1'b0; vif.filt_mode = 2'd1;
    pluck(4);
    for (int i = 1; i <= 4; i++) begin vif.noise = DW'(100 * i); send(8); end
    repeat (4) send(8);

    // Minimum length clamp, three-tap filter, over-unity decay clamp, random noise.
    vif.filt_mode = 2'd2; vif.decay = 13'd8191; vif.velocity = 7'd90;
    pluck(0);
    repeat (10) begin vif.noise = DW'($urandom); send(8); end
    vif.filt_mode = 2'd3;
    repeat (4) send(8);

    // Zero decay: silence ends the note after one full period of quiet samples.
    vif.filt_mode = 2'd0; vif.decay = 13'd0; vif.noise = 24'sd1048576; vif.velocity = 7'd127;
    pluck(8);
    repeat (16) send(8);
    check("idle_after_silence", vif.busy, 0);

    // Retrigger during ring, coincident with a strobe.
    vif.decay = 13'd3000;
    pluck(8);
    repeat (11) send(8);
    vif.delay_length = 10'd5; vif.noise = -24'sd777;
    vif.trig = 1'b1;
    m_trig(5);
    send(8);
    vif.trig = 1'b0;
    repeat (7) send(8);

    // Reset in the middle of a note, then a fresh note.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    check("midnote_rst_busy", vif.busy, 0);
    check("midnote_rst_out", vif.sample_out, 0);
    vif.filt_mode = 2'd2; vif.decay = 13'd4000; vif.velocity = 7'd64;
    pluck(6);
    repeat (10) begin vif.noise = DW'($urandom); send(8); end

    // Back-to-back strobes two cycles apart.
    send(2);
    vif.sample_en = 1'b1;
    tick();
    vif.sample_en = 1'b0;
    repeat (8) tick();
    check("overrun_set", vif.overrun, 1);
    repeat (2) send(8);
    check("overrun_sticky", vif.overrun, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    check("overrun_cleared", vif.overrun, 0);

    repeat (10) tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
